coalescing_store_buffer: RTL and testbench

//  Parametrised successor to the MEM-stage store buffer. Sits between the MEM stage and the dm cache FSM.

---
 rtl/sb_pkg.sv | 32 +++
 rtl/sb_fwd_merge.sv | 35 +++
 rtl/coalescing_store_buffer.sv | 178 +++++++++++++++++
 tb/tb_coalescing_store_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and helpers for the coalescing store buffer.
// Entry field widths are fixed here; override ADDR_W/DATA_W only together with these.
package sb_pkg;

  localparam int SB_ADDR_W  = 32;
  localparam int SB_DATA_W  = 32;
  localparam int SB_BYTES   = SB_DATA_W / 8;
  localparam int SB_OFF_W   = $clog2(SB_BYTES);
  localparam int SB_WADDR_W = SB_ADDR_W - SB_OFF_W;

  typedef struct packed {
    logic                  valid;
    logic [SB_WADDR_W-1:0] word_addr;
    logic [SB_DATA_W-1:0]  data;
    logic [SB_BYTES-1:0]   wstrb;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_FORCE
  } sb_drain_state_e;

  function automatic logic [SB_DATA_W-1:0] lane_mask(input logic [SB_BYTES-1:0] strb);
    logic [SB_DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < SB_BYTES; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Combinational store-to-load forwarding: walks entries oldest to youngest so
// the youngest matching strobed byte wins in each lane.
module sb_fwd_merge
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t              entries [DEPTH],
  input  logic [PTR_W-1:0]       head,
  input  logic [SB_WADDR_W-1:0]  ld_word,
  output logic [SB_DATA_W-1:0]   data,
  output logic [SB_BYTES-1:0]    hit_mask
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    data     = '0;
    hit_mask = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (entries[idx].valid && (entries[idx].word_addr == ld_word)) begin
        for (int b = 0; b < SB_BYTES; b++) begin
          if (entries[idx].wstrb[b]) begin
            data[b*8 +: 8] = entries[idx].data[b*8 +: 8];
            hit_mask[b]    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/coalescing_store_buffer.sv
// Byte-strobed store buffer with forwarding and watermark/forced in-order drain.
// Optional feature: define SB_COALESCE_EN to merge stores into the youngest entry.
module coalescing_store_buffer
  import sb_pkg::*;
#(
  parameter int ADDR_W     = SB_ADDR_W,
  parameter int DATA_W     = SB_DATA_W,
  parameter int DEPTH      = 4,
  parameter int HIGH_WATER = DEPTH,
  parameter int LOW_WATER  = DEPTH / 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [ADDR_W-1:0]          enq_addr,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic [DATA_W/8-1:0]        enq_wstrb,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic [DATA_W-1:0]          ld_data,
  output logic [DATA_W/8-1:0]        ld_hit_mask,
  output logic                       ld_full_hit,
  input  logic                       mem_port_busy,
  input  logic                       drain_force,
  output logic                       drain_valid,
  input  logic                       drain_ready,
  output logic [ADDR_W-1:0]          drain_addr,
  output logic [DATA_W-1:0]          drain_data,
  output logic [DATA_W/8-1:0]        drain_wstrb,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       stall
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t             entries_reg [DEPTH];
  logic [PTR_W-1:0]      head_reg;
  logic [PTR_W-1:0]      tail_reg;
  logic [PTR_W-1:0]      youngest;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  sb_drain_state_e       state_reg;
  logic                  forced_reg;
  logic                  drain_valid_reg;
  logic                  stall_reg;

  logic [ADDR_W-OFF_W-1:0] enq_word;
  logic [DATA_W-1:0]       enq_lanes;
  sb_entry_t               new_entry;
  logic [DATA_W-1:0]       merge_data;
  logic                    coalesce_hit;
  logic                    enq_fire;
  logic                    do_alloc;
  logic                    do_merge;
  logic                    pop;
  logic                    go_force;
  logic                    exit_force;
  logic                    force_next;
  logic                    unused_low_bits;

  assign enq_word   = enq_addr[ADDR_W-1:OFF_W];
  assign enq_lanes  = lane_mask(enq_wstrb);
  assign youngest   = tail_reg - PTR_W'(1);
  assign new_entry  = {1'b1, enq_word, enq_data & enq_lanes, enq_wstrb};
  assign merge_data = (entries_reg[youngest].data & ~enq_lanes) | (enq_data & enq_lanes);
  assign unused_low_bits = ^{enq_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};

`ifdef SB_COALESCE_EN
  // The head is frozen while offered, so merging into it would race the cache.
  assign coalesce_hit = enq_valid && (count_reg != '0) && entries_reg[youngest].valid &&
                        (entries_reg[youngest].word_addr == enq_word) &&
                        !(drain_valid_reg && (youngest == head_reg));
`else
  assign coalesce_hit = 1'b0;
`endif

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign enq_ready = ~full | coalesce_hit;
  assign enq_fire  = enq_valid & enq_ready;
  assign do_merge  = enq_fire & coalesce_hit;
  assign do_alloc  = enq_fire & ~coalesce_hit & (|enq_wstrb);
  assign pop       = drain_valid_reg & drain_ready;

  assign count_next = count_reg + CNT_W'(do_alloc) - CNT_W'(pop);

  // A fence seen at any point in FORCE turns the exit target into "empty".
  assign go_force   = drain_force | (count_reg >= CNT_W'(HIGH_WATER));
  assign exit_force = (forced_reg | drain_force) ? (count_next == '0)
                                                 : (count_next <= CNT_W'(LOW_WATER));
  assign force_next = (state_reg == SB_IDLE) ? go_force : ~exit_force;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i].valid <= 1'b0;
      end
    end else begin
      if (do_alloc) begin
        entries_reg[tail_reg] <= new_entry;
      end
      if (do_merge) begin
        entries_reg[youngest].data  <= merge_data;
        entries_reg[youngest].wstrb <= entries_reg[youngest].wstrb | enq_wstrb;
      end
      if (pop) begin
        entries_reg[head_reg].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      state_reg       <= SB_IDLE;
      forced_reg      <= 1'b0;
      drain_valid_reg <= 1'b0;
      stall_reg       <= 1'b0;
    end else begin
      if (do_alloc) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)      head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_next;
      case (state_reg)
        SB_IDLE: begin
          if (go_force) begin
            state_reg  <= SB_FORCE;
            forced_reg <= drain_force;
            stall_reg  <= 1'b1;
          end
        end
        SB_FORCE: begin
          if (exit_force) begin
            state_reg  <= SB_IDLE;
            forced_reg <= 1'b0;
            stall_reg  <= 1'b0;
          end else begin
            forced_reg <= forced_reg | drain_force;
          end
        end
        default: begin
          state_reg <= SB_IDLE;
          stall_reg <= 1'b0;
        end
      endcase
      // An offer is never retracted by mem_port_busy; only a handshake clears it.
      drain_valid_reg <= (drain_valid_reg & ~drain_ready) |
                         ((count_next != '0) & (force_next | ~mem_port_busy));
    end
  end

  assign drain_valid = drain_valid_reg;
  assign drain_addr  = {entries_reg[head_reg].word_addr, {OFF_W{1'b0}}};
  assign drain_data  = entries_reg[head_reg].data;
  assign drain_wstrb = entries_reg[head_reg].wstrb;
  assign count       = count_reg;
  assign stall       = stall_reg;

  sb_fwd_merge #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .entries  (entries_reg),
    .head     (head_reg),
    .ld_word  (ld_addr[ADDR_W-1:OFF_W]),
    .data     (ld_data),
    .hit_mask (ld_hit_mask)
  );

  assign ld_full_hit = &ld_hit_mask;

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_coalescing_store_buffer;

  localparam int DEPTH = 4;
  localparam int HW    = 4;
  localparam int LW    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_addr = '0;
  logic [31:0] enq_data = '0;
  logic [3:0]  enq_wstrb = '0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data;
  logic [3:0]  ld_hit_mask;
  logic        ld_full_hit;
  logic        mem_port_busy = 1'b0;
  logic        drain_force = 1'b0;
  logic        drain_valid;
  logic        drain_ready = 1'b0;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  drain_wstrb;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        stall;

  always #5 clock = ~clock;

  coalescing_store_buffer dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_wstrb(enq_wstrb),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit_mask(ld_hit_mask), .ld_full_hit(ld_full_hit),
    .mem_port_busy(mem_port_busy), .drain_force(drain_force),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
    .drain_data(drain_data), .drain_wstrb(drain_wstrb),
    .flush(flush), .count(count), .full(full), .empty(empty), .stall(stall)
  );

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  strb;
  } ment_t;

  ment_t       mq[$];
  int          mmode = 0;   // 0 idle, 1 watermark drain, 2 drain-to-empty
  bit          moff = 1'b0;
  logic [31:0] drained[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic bit m_hit();
`ifdef SB_COALESCE_EN
    return enq_valid && (mq.size() > 0) && (mq[mq.size()-1].word == enq_addr[31:2]) &&
           !(moff && mq.size() == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [31:0] eld;
    logic [3:0]  emask;
    int          oldc;
    int          newc;
    bit          hit;
    bit          rdy;
    bit          pop;
    ment_t       ne;
    #1;
    eld = '0;
    emask = '0;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].word == ld_addr[31:2])
        for (int b = 0; b < 4; b++)
          if (mq[i].strb[b]) begin
            eld[b*8 +: 8] = mq[i].data[b*8 +: 8];
            emask[b] = 1'b1;
          end
    hit = m_hit();
    rdy = (mq.size() < DEPTH) || hit;
    chk("enq_ready",   32'(enq_ready),   32'(rdy));
    chk("count",       32'(count),       32'(mq.size()));
    chk("full",        32'(full),        32'(mq.size() == DEPTH));
    chk("empty",       32'(empty),       32'(mq.size() == 0));
    chk("stall",       32'(stall),       32'(mmode != 0));
    chk("drain_valid", 32'(drain_valid), 32'(moff));
    chk("ld_data",     ld_data,          eld);
    chk("ld_mask",     32'(ld_hit_mask), 32'(emask));
    chk("ld_full_hit", 32'(ld_full_hit), 32'(emask == 4'hF));
    if (moff && mq.size() > 0) begin
      chk("drain_addr",  drain_addr,        {mq[0].word, 2'b00});
      chk("drain_data",  drain_data,        mq[0].data);
      chk("drain_wstrb", 32'(drain_wstrb),  32'(mq[0].strb));
    end
    if (enq_valid && enq_ready)
      $display("txn enq   addr=%h data=%h strb=%b", enq_addr, enq_data, enq_wstrb);
    if (drain_valid && drain_ready) begin
      $display("txn drain addr=%h data=%h strb=%b", drain_addr, drain_data, drain_wstrb);
      drained.push_back(drain_addr);
    end
    @(posedge clock);
    if (reset || flush) begin
      mq.delete();
      mmode = 0;
      moff = 1'b0;
    end else begin
      oldc = mq.size();
      pop = moff && drain_ready;
      if (enq_valid && rdy) begin
        if (hit) begin
          mq[mq.size()-1].data = (mq[mq.size()-1].data & ~bmask(enq_wstrb)) |
                                 (enq_data & bmask(enq_wstrb));
          mq[mq.size()-1].strb = mq[mq.size()-1].strb | enq_wstrb;
        end else if (enq_wstrb != 0) begin
          ne.word = enq_addr[31:2];
          ne.data = enq_data & bmask(enq_wstrb);
          ne.strb = enq_wstrb;
          mq.push_back(ne);
        end
      end
      if (pop) ne = mq.pop_front();
      newc = mq.size();
      if (mmode == 0) begin
        if (drain_force || oldc >= HW) mmode = drain_force ? 2 : 1;
      end else begin
        if (drain_force) mmode = 2;
        if ((mmode == 2 && newc == 0) || (mmode == 1 && newc <= LW)) mmode = 0;
      end
      moff = (moff && !drain_ready) || (newc != 0 && (mmode != 0 || !mem_port_busy));
    end
    @(negedge clock);
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    enq_valid = 1'b1;
    enq_addr = a;
    enq_data = d;
    enq_wstrb = s;
    step();
    enq_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    step();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_drain_valid", 32'(drain_valid), 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_stall", 32'(stall), 0);

    // 1: fill while the pipeline owns the cache, watermark drain down to LOW_WATER
    mem_port_busy = 1'b1;
    drain_ready = 1'b0;
    drained.delete();
    for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF);
    #1;
    chk("t1_full", 32'(full), 1);
    chk("t1_count4", 32'(count), 4);
    step();
    #1;
    chk("t1_stall", 32'(stall), 1);
    drain_ready = 1'b1;
    repeat (6) step();
    #1;
    chk("t1_low_count", 32'(count), 2);
    chk("t1_low_stall", 32'(stall), 0);
    mem_port_busy = 1'b0;
    repeat (6) step();
    #1;
    chk("t1_empty", 32'(empty), 1);
    chk("t1_drain_n", 32'(drained.size()), 4);
    for (int i = 0; i < drained.size() && i < 4; i++)
      chk("t1_order", drained[i], 32'h100 + 32'(4*i));

    // 2: two partial stores to one word forward as a merged pair of lanes
    mem_port_busy = 1'b1;
    drain_ready = 1'b0;
    enq(32'h200, 32'h0000_00AA, 4'b0001);
    enq(32'h200, 32'h0000_BB00, 4'b0010);
    ld_addr = 32'h200;
    #1;
    chk("t2_ld_data", ld_data, 32'h0000_BBAA);
    chk("t2_ld_mask", 32'(ld_hit_mask), 32'h3);
    chk("t2_full_hit", 32'(ld_full_hit), 0);
    mem_port_busy = 1'b0;
    drain_ready = 1'b1;
    repeat (6) step();

    // 3: complementary halves of one word
    mem_port_busy = 1'b1;
    drain_ready = 1'b0;
    enq(32'h300, 32'h0000_3344, 4'b0011);
    enq(32'h300, 32'h5566_0000, 4'b1100);
    #1;
`ifdef SB_COALESCE_EN
    chk("t3_count", 32'(count), 1);
`else
    chk("t3_count", 32'(count), 2);
`endif
    mem_port_busy = 1'b0;
    repeat (2) step();
    #1;
    chk("t3_valid", 32'(drain_valid), 1);
`ifdef SB_COALESCE_EN
    chk("t3_wstrb", 32'(drain_wstrb), 32'hF);
`else
    chk("t3_wstrb", 32'(drain_wstrb), 32'h3);
`endif
    drain_ready = 1'b1;
    repeat (5) step();

    // 4: offer held across mem_port_busy toggles until accepted
    drain_ready = 1'b0;
    mem_port_busy = 1'b1;
    enq(32'h400, 32'hDEAD_BEEF, 4'hF);
    mem_port_busy = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      mem_port_busy = i[0];
      step();
      #1;
      chk("t4_hold_valid", 32'(drain_valid), 1);
      chk("t4_hold_addr", drain_addr, 32'h400);
      chk("t4_hold_data", drain_data, 32'hDEAD_BEEF);
    end
    mem_port_busy = 1'b0;
    drain_ready = 1'b1;
    step();
    #1;
    chk("t4_accepted", 32'(empty), 1);

    // 5: store against a full buffer in the same cycle as a drain
    drain_ready = 1'b0;
    mem_port_busy = 1'b1;
    for (int i = 0; i < 4; i++) enq(32'h500 + 32'(4*i), $urandom(), 4'hF);
    step();
    enq_valid = 1'b1;
    enq_addr = 32'h510;
    enq_data = 32'h0510_0510;
    enq_wstrb = 4'hF;
    drain_ready = 1'b1;
    #1;
    chk("t5_enq_ready_full", 32'(enq_ready), 0);
    step();
    drain_ready = 1'b0;
    #1;
    chk("t5_enq_ready_next", 32'(enq_ready), 1);
    step();
    enq_valid = 1'b0;
    #1;
    chk("t5_count", 32'(count), 4);

    // 6: flush, then reset, during an active drain with three entries
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    #1;
    chk("t6_pre_count", 32'(count), 3);
    chk("t6_pre_valid", 32'(drain_valid), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t6_fl_count", 32'(count), 0);
    chk("t6_fl_valid", 32'(drain_valid), 0);
    chk("t6_fl_empty", 32'(empty), 1);
    chk("t6_fl_stall", 32'(stall), 0);
    mem_port_busy = 1'b1;
    for (int i = 0; i < 3; i++) enq(32'h700 + 32'(4*i), $urandom(), 4'hF);
    mem_port_busy = 1'b0;
    step();
    #1;
    chk("t6_pre2_valid", 32'(drain_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t6_rs_count", 32'(count), 0);
    chk("t6_rs_valid", 32'(drain_valid), 0);
    chk("t6_rs_empty", 32'(empty), 1);
    chk("t6_rs_stall", 32'(stall), 0);

    // random traffic over four words so coalescing and forwarding collide often
    for (int n = 0; n < 400; n++) begin
      enq_valid     = 1'($urandom_range(0, 1));
      enq_addr      = 32'h600 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      enq_data      = $urandom();
      enq_wstrb     = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ld_addr       = 32'h600 + 32'(4 * $urandom_range(0, 3));
      mem_port_busy = 1'($urandom_range(0, 1));
      drain_ready   = ($urandom_range(0, 2) != 0);
      drain_force   = ($urandom_range(0, 19) == 0);
      flush         = ($urandom_range(0, 49) == 0);
      reset         = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
